// File: rtl/ascon_pkg.sv
// Shared Ascon permutation types: the 5x64 state and the folded substitution FSM.
package ascon_pkg;

  localparam int ASCON_NUM_COLUMNS = 64;

  // Row r, column j is state[r][j]; row 0 is the MSB of each S-box input.
  typedef logic [4:0][ASCON_NUM_COLUMNS-1:0] t_state_array;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } t_sub_fsm;

endpackage

// File: rtl/sbox.sv
// Ascon 5-bit S-box, bitsliced form; i_x[4] is x0 (row 0), i_x[0] is x4 (row 4).
module sbox (
  input  logic [4:0] i_x,
  output logic [4:0] o_y
);

  logic x0, x1, x2, x3, x4;
  logic t0, t1, t2, t3, t4;

  // Keccak-style chi sandwiched between the Ascon affine input/output layers
  always_comb begin
    x0 = i_x[4];
    x1 = i_x[3];
    x2 = i_x[2];
    x3 = i_x[1];
    x4 = i_x[0];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    o_y = {x0, x1, x2, x3, x4};
  end

endmodule

// File: rtl/sub_layer_folded.sv
// Folded Ascon substitution layer: SBOXES_PER_CYCLE columns per clock over
// NUM_SBOXES/SBOXES_PER_CYCLE passes, valid/ready on both sides.
module sub_layer_folded
  import ascon_pkg::*;
#(
  parameter int NUM_SBOXES       = ASCON_NUM_COLUMNS,
  parameter int SBOXES_PER_CYCLE = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  t_state_array i_state,
  output logic         o_valid,
  input  logic         i_ready,
  output t_state_array o_state
);

  localparam int N     = NUM_SBOXES / SBOXES_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int COL_W = $clog2(NUM_SBOXES);

  if (NUM_SBOXES % SBOXES_PER_CYCLE != 0) begin : g_bad_fold
    $error("SBOXES_PER_CYCLE must divide NUM_SBOXES");
  end
  if (NUM_SBOXES != ASCON_NUM_COLUMNS) begin : g_bad_width
    $error("NUM_SBOXES must equal the state column count");
  end
  if (SBOXES_PER_CYCLE < 1 || SBOXES_PER_CYCLE > NUM_SBOXES) begin : g_bad_range
    $error("SBOXES_PER_CYCLE out of range");
  end

  t_sub_fsm         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  t_state_array     work_q, work_d;
  logic             valid_q, valid_d;

  logic [4:0] sb_in  [SBOXES_PER_CYCLE];
  logic [4:0] sb_out [SBOXES_PER_CYCLE];

  // Column handled by S-box k during pass c
  function automatic logic [COL_W-1:0] col_of(input logic [CNT_W-1:0] c, input int k);
    return COL_W'(int'(c) * SBOXES_PER_CYCLE + k);
  endfunction

  // Chunk-select mux: gather the current pass's columns into S-box inputs
  always_comb begin
    for (int k = 0; k < SBOXES_PER_CYCLE; k++) begin
      sb_in[k] = {work_q[0][col_of(cnt_q, k)], work_q[1][col_of(cnt_q, k)],
                  work_q[2][col_of(cnt_q, k)], work_q[3][col_of(cnt_q, k)],
                  work_q[4][col_of(cnt_q, k)]};
    end
  end

  for (genvar k = 0; k < SBOXES_PER_CYCLE; k++) begin : g_sbox
    sbox u_sbox (
      .i_x (sb_in[k]),
      .o_y (sb_out[k])
    );
  end

  // Handshake FSM, pass counter and in-place write-back of substituted columns
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    o_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          work_d  = i_state;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < SBOXES_PER_CYCLE; k++) begin
          work_d[0][col_of(cnt_q, k)] = sb_out[k][4];
          work_d[1][col_of(cnt_q, k)] = sb_out[k][3];
          work_d[2][col_of(cnt_q, k)] = sb_out[k][2];
          work_d[3][col_of(cnt_q, k)] = sb_out[k][1];
          work_d[4][col_of(cnt_q, k)] = sb_out[k][0];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Result is held until taken; a new state may enter on the same edge
        o_ready = i_ready;
        if (i_ready) begin
          if (i_valid) begin
            work_d  = i_state;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
  end

  // State, counter, working state and output-valid registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_state = work_q;

endmodule

// File: tb/tb_sub_layer_folded.sv
// Bench for sub_layer_folded: table-driven S-box reference, handshake scenarios.
module tb_sub_layer_folded;
  import ascon_pkg::*;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         i_valid, i_ready;
  t_state_array i_state;
  logic         o_ready, o_valid;
  t_state_array o_state;
  logic         r1, v1, r8, v8, r64, v64;
  t_state_array s1, s8, s64;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] SBOX_TBL [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  always #5 clock = ~clock;

  sub_layer_folded dut (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_state(i_state), .o_valid(o_valid), .i_ready(i_ready), .o_state(o_state));
  sub_layer_folded #(.SBOXES_PER_CYCLE(1)) dut_p1 (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .o_ready(r1),
    .i_state(i_state), .o_valid(v1), .i_ready(i_ready), .o_state(s1));
  sub_layer_folded #(.SBOXES_PER_CYCLE(8)) dut_p8 (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .o_ready(r8),
    .i_state(i_state), .o_valid(v8), .i_ready(i_ready), .o_state(s8));
  sub_layer_folded #(.SBOXES_PER_CYCLE(64)) dut_p64 (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .o_ready(r64),
    .i_state(i_state), .o_valid(v64), .i_ready(i_ready), .o_state(s64));

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic t_state_array sub_ref(input t_state_array s);
    t_state_array r;
    logic [4:0]   v, y;
    for (int j = 0; j < 64; j++) begin
      v = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      y = SBOX_TBL[v];
      {r[0][j], r[1][j], r[2][j], r[3][j], r[4][j]} = y;
    end
    return r;
  endfunction

  function automatic t_state_array rand_state();
    t_state_array r;
    for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_state = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // One transaction on the default instance, starting from IDLE
  task automatic xfer(input t_state_array s, input t_state_array exp, input string tag);
    int lat;
    bit ok;
    i_state = s;
    i_valid = 1'b1;
    i_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check({tag, " accepted"}, 320'(ok), 320'(1));
    step();
    i_valid = 1'b0;
    i_state = rand_state();
    lat = 0;
    while (!o_valid && lat < 200) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 320'(lat), 320'(4));
    check({tag, " data"}, o_state, exp);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check({tag, " released"}, 320'(o_valid), 320'(0));
  endtask

  initial begin
    t_state_array a, exp_c;
    t_state_array expq[$];
    int l4, l1, l8, l64, last_acc, n_acc;
    bit acc_now;

    reset_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_state = '0;
    step();
    check("reset o_valid", 320'(o_valid), 320'(0));
    check("reset o_ready", 320'(o_ready), 320'(1));
    check("reset o_state", o_state, '0);
    do_reset();

    // All-zero state: row 2 set, everything else clear
    exp_c = '0;
    exp_c[2] = '1;
    xfer('0, exp_c, "zeros");

    // All-ones on every fold factor: same result, latency 64/N
    do_reset();
    exp_c = '1;
    exp_c[1] = '0;
    i_state = '1;
    i_valid = 1'b1;
    i_ready = 1'b0;
    step();
    i_valid = 1'b0;
    i_state = rand_state();
    l4 = -1; l1 = -1; l8 = -1; l64 = -1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      step();
      if (o_valid && l4 < 0) l4 = cyc;
      if (v1 && l1 < 0) l1 = cyc;
      if (v8 && l8 < 0) l8 = cyc;
      if (v64 && l64 < 0) l64 = cyc;
    end
    check("ones lat spc16", 320'(l4), 320'(4));
    check("ones lat spc1", 320'(l1), 320'(64));
    check("ones lat spc8", 320'(l8), 320'(8));
    check("ones lat spc64", 320'(l64), 320'(1));
    check("ones data spc16", o_state, exp_c);
    check("ones data spc1", s1, exp_c);
    check("ones data spc8", s8, exp_c);
    check("ones data spc64", s64, exp_c);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;

    // Column j carries j mod 32: every S-box table entry appears twice
    a = '0;
    for (int j = 0; j < 64; j++) begin
      {a[0][j], a[1][j], a[2][j], a[3][j], a[4][j]} = 5'(j % 32);
    end
    exp_c = '0;
    for (int j = 0; j < 64; j++) begin
      {exp_c[0][j], exp_c[1][j], exp_c[2][j], exp_c[3][j], exp_c[4][j]} = SBOX_TBL[j % 32];
    end
    xfer(a, exp_c, "ramp");

    for (int t = 0; t < 1000; t++) begin
      a = rand_state();
      xfer(a, sub_ref(a), "random");
    end

    // Backpressure: result held, input ignored, exactly one transfer on release
    a = rand_state();
    i_state = a;
    i_valid = 1'b1;
    i_ready = 1'b0;
    step();
    i_valid = 1'b0;
    for (int i = 0; i < 20 && !o_valid; i++) step();
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'($urandom);
      i_state = rand_state();
      step();
      check("bp o_valid", 320'(o_valid), 320'(1));
      check("bp o_ready", 320'(o_ready), 320'(0));
      check("bp o_state", o_state, sub_ref(a));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    check("bp release ready", 320'(o_ready), 320'(1));
    step();
    check("bp one transfer", 320'(o_valid), 320'(0));
    for (int i = 0; i < 5; i++) step();
    check("bp no duplicate", 320'(o_valid), 320'(0));
    i_ready = 1'b0;

    // Back-to-back streaming with valid and ready held high
    expq.delete();
    last_acc = -1;
    n_acc = 0;
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_state = rand_state();
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc_now = 1'b0;
      if (o_valid) begin
        if (expq.size() == 0) check("stream spurious", 320'(1), 320'(0));
        else check("stream data", o_state, expq.pop_front());
      end
      if (o_ready) begin
        expq.push_back(sub_ref(i_state));
        if (last_acc >= 0) check("stream interval", 320'(cyc - last_acc), 320'(5));
        last_acc = cyc;
        n_acc++;
        acc_now = 1'b1;
      end
      step();
      if (acc_now) i_state = rand_state();
    end
    i_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_valid) begin
        if (expq.size() == 0) check("drain spurious", 320'(1), 320'(0));
        else check("drain data", o_state, expq.pop_front());
      end
      step();
    end
    check("stream accepts", 320'(n_acc), 320'(12));
    check("stream all out", 320'(expq.size()), 320'(0));
    i_ready = 1'b0;

    // Reset in the middle of BUSY, then a clean transaction
    i_state = rand_state();
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("midreset o_valid", 320'(o_valid), 320'(0));
    check("midreset o_ready", 320'(o_ready), 320'(1));
    check("midreset o_state", o_state, '0);
    step();
    reset_n = 1'b1;
    step();
    a = rand_state();
    xfer(a, sub_ref(a), "post reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
